// File: rtl/updown_pkg.sv
// Shared constants and FSM state encoding for the up/down word generator.
// Provides default data_width/cnt_width and the state_t enum.
package updown_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CNT_W_DEF  = 6;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/updown_gen_bitgen.sv
// Bit emitter: holds start level, remaining toggles and the shift register.
// Ports: clk, reset, i_load (init), i_shift (emit one bit), i_rise/i_fall,
// o_sr (shift register), o_last (this shift emits the final bit).
module updown_gen_bitgen #(
   parameter int data_width = 32,
   parameter int cnt_width  = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_load,
   input  logic                  i_shift,
   input  logic [cnt_width-1:0]  i_rise,
   input  logic [cnt_width-1:0]  i_fall,
   output logic [data_width-1:0] o_sr,
   output logic                  o_last
);

   localparam int IW = $clog2(data_width);

   logic                  r_lvl;
   logic [cnt_width:0]    r_tog;
   logic [IW-1:0]         r_idx;
   logic [data_width-1:0] r_sr;
   logic                  w_first;
   logic                  w_bit;

   assign w_first = (r_idx == '0);
   assign o_last  = (r_idx == IW'(data_width - 1));
   assign o_sr    = r_sr;

   // First bit is the start level and consumes no toggle.
   always_comb begin
      w_bit = r_sr[0];
      if (w_first)
         w_bit = r_lvl;
      else if (r_tog != '0)
         w_bit = ~r_sr[0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_lvl <= 1'b0;
         r_tog <= '0;
         r_idx <= '0;
         r_sr  <= '0;
      end else if (i_load) begin
         r_lvl <= (i_fall > i_rise);
         r_tog <= {1'b0, i_rise} + {1'b0, i_fall};
         r_idx <= '0;
         r_sr  <= '0;
      end else if (i_shift) begin
         r_sr  <= {r_sr[data_width-2:0], w_bit};
         r_idx <= r_idx + IW'(1);
         if (!w_first && r_tog != '0)
            r_tog <= r_tog - 1'b1;
      end
   end

endmodule

// File: rtl/updown_gen.sv
// Generates a data word with a requested number of rises and falls.
// Ports: clk, reset, start, rise_cnt, fall_cnt -> busy, done, err, data
// (+ parity when UPDOWN_GEN_PARITY_EN is defined).
module updown_gen
   import updown_pkg::*;
#(
   parameter int data_width = DATA_W_DEF,
   parameter int cnt_width  = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [cnt_width-1:0]  rise_cnt,
   input  logic [cnt_width-1:0]  fall_cnt,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
`ifdef UPDOWN_GEN_PARITY_EN
   output logic                  parity,
`endif
   output logic [data_width-1:0] data
);

   state_t                r_state;
   state_t                w_next;
   logic [cnt_width-1:0]  r_rise;
   logic [cnt_width-1:0]  r_fall;
   logic                  r_bad;
   logic                  r_done;
   logic                  r_err;
   logic [data_width-1:0] r_data;
`ifdef UPDOWN_GEN_PARITY_EN
   logic                  r_par;
`endif

   logic                  w_load;
   logic                  w_shift;
   logic                  w_last;
   logic                  w_infeas;
   logic [data_width-1:0] w_sr;
   logic [31:0]           w_r32;
   logic [31:0]           w_f32;
   logic [31:0]           w_sum;
   logic [31:0]           w_diff;

   // 32-bit arithmetic keeps rise+fall free of overflow at cnt_width.
   assign w_r32    = 32'(r_rise);
   assign w_f32    = 32'(r_fall);
   assign w_sum    = w_r32 + w_f32;
   assign w_diff   = (w_r32 >= w_f32) ? w_r32 - w_f32 : w_f32 - w_r32;
   assign w_infeas = (w_diff > 32'd1) || (w_sum > 32'(data_width - 1));

   always_comb begin
      w_next  = r_state;
      w_load  = 1'b0;
      w_shift = 1'b0;
      unique case (r_state)
         S_IDLE:
            if (start) w_next = S_CHECK;
         S_CHECK: begin
            // Infeasible requests pass through DONE so err and done
            // share the same registered pulse path.
            w_load = !w_infeas;
            w_next = w_infeas ? S_DONE : S_SHIFT;
         end
         S_SHIFT: begin
            w_shift = 1'b1;
            if (w_last) w_next = S_DONE;
         end
         S_DONE:
            w_next = S_IDLE;
         default:
            w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_rise  <= '0;
         r_fall  <= '0;
         r_bad   <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_data  <= '0;
`ifdef UPDOWN_GEN_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         if (r_state == S_IDLE && start) begin
            r_rise <= rise_cnt;
            r_fall <= fall_cnt;
         end
         if (r_state == S_CHECK)
            r_bad <= w_infeas;
         if (r_state == S_DONE) begin
            if (r_bad) begin
               r_err  <= 1'b1;
            end else begin
               r_done <= 1'b1;
               r_data <= w_sr;
`ifdef UPDOWN_GEN_PARITY_EN
               r_par  <= ^w_sr;
`endif
            end
         end
      end
   end

   updown_gen_bitgen #(
      .data_width (data_width),
      .cnt_width  (cnt_width)
   ) u_bitgen (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_rise  (r_rise),
      .i_fall  (r_fall),
      .o_sr    (w_sr),
      .o_last  (w_last)
   );

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign err  = r_err;
   assign data = r_data;
`ifdef UPDOWN_GEN_PARITY_EN
   assign parity = r_par;
`endif

endmodule

// File: tb/tb_updown_gen.sv
// Directed bench for updown_gen with an expected-result queue.
// Parity checks are enabled with UPDOWN_GEN_PARITY_EN.
module tb_updown_gen;

   localparam int DW = 32;
   localparam int CW = 6;

   typedef struct {
      logic        is_err;
      logic        chk;
      logic [31:0] data;
      int          lat;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [CW-1:0] rise_cnt;
   logic [CW-1:0] fall_cnt;
   logic          busy;
   logic          done;
   logic          err;
   logic [DW-1:0] data;
`ifdef UPDOWN_GEN_PARITY_EN
   logic          parity;
`endif

   int          total = 0;
   int          bad   = 0;
   exp_t        sb[$];
   logic [31:0] last_data;

   always #5 clk = ~clk;

   updown_gen #(.data_width(DW), .cnt_width(CW)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .rise_cnt (rise_cnt),
      .fall_cnt (fall_cnt),
      .busy     (busy),
      .done     (done),
      .err      (err),
`ifdef UPDOWN_GEN_PARITY_EN
      .parity   (parity),
`endif
      .data     (data)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int n_rise(input logic [31:0] w);
      int n = 0;
      for (int i = DW - 1; i > 0; i--)
         if (!w[i] && w[i-1]) n++;
      return n;
   endfunction

   function automatic int n_fall(input logic [31:0] w);
      int n = 0;
      for (int i = DW - 1; i > 0; i--)
         if (w[i] && !w[i-1]) n++;
      return n;
   endfunction

   // Wait for done/err after the start-sampling edge and compare.
   task automatic wait_result(input int glitch);
      int   n   = 0;
      logic got = 1'b0;
      exp_t e;
      while (!got && n < 100) begin
         if (glitch != 0 && n == glitch) begin
            start    = 1'b1;
            rise_cnt = 6'd3;
            fall_cnt = 6'd2;
         end else begin
            start = 1'b0;
         end
         tick();
         n++;
         if (done || err) got = 1'b1;
      end
      start = 1'b0;
      e = sb.pop_front();
      check("timeout", 64'(got), 64'd1);
      check("err", 64'(err), 64'(e.is_err));
      check("done", 64'(done), 64'(!e.is_err));
      check("latency", 64'(n), 64'(e.lat));
      check("busy_end", 64'(busy), 64'd0);
      if (e.chk) begin
         check("data", 64'(data), 64'(e.data));
`ifdef UPDOWN_GEN_PARITY_EN
         check("parity", 64'(parity), 64'(^e.data));
`endif
         last_data = e.data;
      end else begin
         last_data = data;
      end
      tick();
      check("pulse_done", 64'(done), 64'd0);
      check("pulse_err", 64'(err), 64'd0);
      check("data_stable", 64'(data), 64'(last_data));
   endtask

   task automatic req(input int r, input int f, input logic is_err,
                      input logic chk, input logic [31:0] d,
                      input int glitch);
      exp_t e;
      e.is_err = is_err;
      e.chk    = chk;
      e.data   = is_err ? last_data : d;
      e.lat    = is_err ? 2 : DW + 2;
      sb.push_back(e);
      start    = 1'b1;
      rise_cnt = CW'(r);
      fall_cnt = CW'(f);
      tick();
      start = 1'b0;
      check("busy_start", 64'(busy), 64'd1);
      wait_result(glitch);
   endtask

   initial begin
      int n;
      logic seen;
      reset     = 1'b1;
      start     = 1'b0;
      rise_cnt  = '0;
      fall_cnt  = '0;
      last_data = '0;
      repeat (3) tick();
      reset = 1'b0;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_data", 64'(data), 64'd0);
`ifdef UPDOWN_GEN_PARITY_EN
      check("rst_parity", 64'(parity), 64'd0);
`endif
      tick();

      req(2, 2, 1'b0, 1'b1, 32'h5000_0000, 0);
      req(3, 2, 1'b0, 1'b1, 32'h57FF_FFFF, 0);
      req(0, 1, 1'b0, 1'b1, 32'h8000_0000, 0);
      req(0, 0, 1'b0, 1'b1, 32'h0000_0000, 0);
      req(16, 15, 1'b0, 1'b1, 32'h5555_5555, 0);
      req(3, 1, 1'b1, 1'b1, 32'h0, 0);
      req(16, 16, 1'b1, 1'b1, 32'h0, 0);
      check("err_keeps", 64'(data), 64'h5555_5555);

      req(5, 5, 1'b0, 1'b0, 32'h0, 0);
      check("rises_5_5", 64'(n_rise(data)), 64'd5);
      check("falls_5_5", 64'(n_fall(data)), 64'd5);
      req(7, 6, 1'b0, 1'b0, 32'h0, 0);
      check("rises_7_6", 64'(n_rise(data)), 64'd7);
      check("falls_7_6", 64'(n_fall(data)), 64'd6);
      req(2, 3, 1'b0, 1'b0, 32'h0, 0);
      check("rises_2_3", 64'(n_rise(data)), 64'd2);
      check("falls_2_3", 64'(n_fall(data)), 64'd3);

      req(2, 2, 1'b0, 1'b1, 32'h5000_0000, 10);

      // Reset while shifting.
      start    = 1'b1;
      rise_cnt = 6'd3;
      fall_cnt = 6'd2;
      tick();
      start = 1'b0;
      repeat (10) tick();
      check("mid_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rs_busy", 64'(busy), 64'd0);
      check("rs_data", 64'(data), 64'd0);
      check("rs_done", 64'(done), 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done || err || busy) seen = 1'b1;
      end
      check("rs_quiet", 64'(seen), 64'd0);
      check("rs_data2", 64'(data), 64'd0);
      last_data = '0;

      // Held start: re-accepted one cycle after returning to IDLE.
      sb.push_back('{1'b0, 1'b1, 32'h8000_0000, DW + 2});
      sb.push_back('{1'b0, 1'b1, 32'h8000_0000, DW + 3});
      start    = 1'b1;
      rise_cnt = 6'd0;
      fall_cnt = 6'd1;
      tick();
      for (int k = 0; k < 2; k++) begin
         exp_t e;
         n = 0;
         seen = 1'b0;
         while (!seen && n < 100) begin
            tick();
            n++;
            if (done) seen = 1'b1;
         end
         e = sb.pop_front();
         check("held_seen", 64'(seen), 64'd1);
         check("held_lat", 64'(n), 64'(e.lat));
         check("held_data", 64'(data), 64'(e.data));
      end
      start = 1'b0;
      repeat (40) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
